window_stream_3x3: RTL and testbench
====================================

// Module: window_stream_3x3
// PURPOSE
//  - Raster-order pixel stream to 3x3 sliding-window generator; feeds kernalpooling's 72-bit window input.
//  - Two internal line buffers plus a 3x3 register array; emits one window per pixel once row>=2 and col>=2.
//  - Valid/ready on both sides; sustains 1 pixel/cycle when unstalled.
// PARAMETERS
//  DWIDTH   8    pixel width, bits
//  IMG_W    64   pixels per line (>=3)
//  IMG_H    64   lines per frame (>=3)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  pix_in     in   DWIDTH      input pixel
//  pix_sof    in   1           start of frame, qualified by pix_valid
//  pix_valid  in   1           pix_in/pix_sof valid
//  pix_ready  out  1           block accepts pixel this cycle
//  win_out    out  9*DWIDTH    window; element (r,c) at [(r*3+c)*DWIDTH +: DWIDTH]
//  win_valid  out  1           win_out valid
//  win_ready  in   1           downstream accepts window
//  win_last   out  1           window is the last of the frame
// BEHAVIOUR
//  - Reset: win_valid=0, win_last=0, win_out=0, col=0, row=0. Line buffer contents are not reset (don't-care).
//  - Accept: acc = pix_valid & pix_ready. pix_ready = !win_valid | win_ready (combinational).
//  - Position: (row,col) of the accepted pixel is (0,0) if pix_sof, else the counters.
//    - After acc, col increments.
//    - At col==IMG_W-1: col->0, row increments.
//    - At (IMG_H-1, IMG_W-1): row->0, col->0.
//  - Line buffers: lb1[col]=line row-1 and lb2[col]=line row-2. Both are asynchronous-read arrays, depth IMG_W.
//    - On acc: lb2[col]<=lb1[col], lb1[col]<=pix_in.
//  - Window shift on acc:
//    - Columns 0,1 <= old columns 1,2.
//    - New column 2 = {r0:lb2[col], r1:lb1[col], r2:pix_in}.
//    - r=0 is the top (oldest) row; c=0 is the leftmost (oldest) column.
//  - Output register, loaded on acc:
//    - win_valid <= (row>=2 && col>=2).
//    - win_out <= shifted window.
//    - win_last <= (row==IMG_H-1 && col==IMG_W-1).
//  - Without acc: if win_ready, win_valid<=0; otherwise all outputs hold.
//  - Latency: window completed by pixel (r,c) is valid the cycle after its acceptance.
//  - Stall: while win_valid & !win_ready, win_out/win_last are stable and pix_ready=0. No pixel is dropped or duplicated.
//  - Simultaneous drain and accept: the new window replaces the old one in the same edge (no bubble).
//  - Line wrap: stale columns from the previous line are gated by col>=2. Stale lines at frame start are gated by row>=2.
//  - pix_sof mid-frame: resync to (0,0); no window is emitted until (2,2) of the new frame.
//  - Reset mid-frame: any pending window is discarded; the next frame must start with pix_sof or after reset.
//  - Windows per frame: (IMG_H-2)*(IMG_W-2).
// STRUCTURE
//  - Shared package window_pkg:
//    - KSIZE=3
//    - WIN_W(DWIDTH)=KSIZE*KSIZE*DWIDTH
//    - function win_idx(r,c)=(r*KSIZE+c) for slice packing, shared with kernalpooling.
//  - One sub-module, line_buffer:
//    - parameters DWIDTH, DEPTH
//    - ports clk, we, addr, din, dout (async read)
//    - instantiated twice (lb1, lb2)
//  - Counters, window array and output register stay in the top level.
// TESTING (IMG_W=4, IMG_H=4, pixel value = row*16+col)
//  1. Full frame, win_ready=1, sof on first pixel:
//     - exactly 4 windows.
//     - First window one cycle after pixel 0x22: [7:0]=0x00, [39:32]=0x11, [71:64]=0x22.
//     - Last window [71:64]=0x33 with win_last=1.
//  2. Backpressure: drop win_ready for 3 cycles on the first window.
//     - win_out is constant and pix_ready=0 for those cycles.
//     - After release, the remaining windows match test 1 exactly.
//  3. Throughput: pix_valid=1 and win_ready=1 throughout.
//     - pix_ready is never low.
//     - Windows appear on consecutive cycles for cols 2,3 of rows 2,3.
//  4. pix_sof asserted at pixel (3,1) of frame 1, then a clean frame follows:
//     - no window until the new (2,2).
//     - Output then matches test 1.
//  5. rst pulse while win_valid=1 mid-frame:
//     - win_valid=0 within the reset.
//     - Next frame with sof yields the test 1 sequence.
//  6. Two back-to-back frames without a gap: 8 windows, win_last exactly twice.

Source files
------------

// File: rtl/window_pkg.sv
// Shared definitions for the 3x3 window stream and its downstream pooling stage.
// KSIZE   : kernel edge length (3)
// win_w   : packed window width for a given pixel width
// win_idx : element (r,c) slot number; the element lives at [win_idx(r,c)*DWIDTH +: DWIDTH]
package window_pkg;

    localparam int KSIZE = 3;

    function automatic int win_w(input int dwidth);
        return KSIZE * KSIZE * dwidth;
    endfunction

    function automatic int win_idx(input int r, input int c);
        return r * KSIZE + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line store with a synchronous write and an asynchronous read.
// The contents are never reset; rows are gated downstream until they hold valid data.
// Ports:
//   clk  : rising-edge clock
//   we   : write enable
//   addr : shared read/write address (column)
//   din  : data written at addr on the clock edge when we=1
//   dout : current contents at addr (combinational read)
module line_buffer #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DWIDTH-1:0]        din,
    output logic [DWIDTH-1:0]        dout
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/window_stream_3x3.sv
// Converts a raster-order pixel stream into 3x3 sliding windows.
// Two line buffers hold the previous two lines; a 3x3 register array shifts left by one
// column per accepted pixel, and the freshly shifted window is registered as the output.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   pix_in     : input pixel
//   pix_sof    : start of frame, forces the accepted pixel to position (0,0)
//   pix_valid  : input handshake valid
//   pix_ready  : input handshake ready (free output register or draining one)
//   win_out    : window, element (r,c) at [(r*3+c)*DWIDTH +: DWIDTH], r=0 top, c=0 left
//   win_valid  : output handshake valid
//   win_ready  : output handshake ready
//   win_last   : marks the final window of a frame
module window_stream_3x3
    import window_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DWIDTH-1:0]               pix_in,
    input  logic                            pix_sof,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    output logic [KSIZE*KSIZE*DWIDTH-1:0]   win_out,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic                            win_last
);

    localparam int WIN_W = win_w(DWIDTH);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(KSIZE - 1);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(KSIZE - 1);

    logic [COL_W-1:0]  col_q, col_d, cur_col;
    logic [ROW_W-1:0]  row_q, row_d, cur_row;
    logic [WIN_W-1:0]  win_q, win_d, win_shift;
    logic              win_valid_q, win_valid_d;
    logic              win_last_q, win_last_d;
    logic              acc;
    logic [DWIDTH-1:0] lb1_dout, lb2_dout;

    assign pix_ready = !win_valid_q | win_ready;
    assign acc       = pix_valid & pix_ready;

    // A start-of-frame pixel is placed at (0,0) regardless of where the counters were.
    always_comb begin
        cur_col = col_q;
        cur_row = row_q;
        if (pix_sof) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    // lb1 holds line row-1 and lb2 line row-2; on each accept the column moves down one line.
    line_buffer #(.DWIDTH(DWIDTH), .DEPTH(IMG_W)) u_lb1 (
        .clk  (clk),
        .we   (acc),
        .addr (cur_col),
        .din  (pix_in),
        .dout (lb1_dout)
    );

    line_buffer #(.DWIDTH(DWIDTH), .DEPTH(IMG_W)) u_lb2 (
        .clk  (clk),
        .we   (acc),
        .addr (cur_col),
        .din  (lb1_dout),
        .dout (lb2_dout)
    );

    // Left shift of the window; the new right column is the vertical slice at cur_col.
    always_comb begin
        win_shift = win_q;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) begin
                win_shift[win_idx(r, c)*DWIDTH +: DWIDTH] = win_q[win_idx(r, c + 1)*DWIDTH +: DWIDTH];
            end
        end
        win_shift[win_idx(0, KSIZE - 1)*DWIDTH +: DWIDTH] = lb2_dout;
        win_shift[win_idx(1, KSIZE - 1)*DWIDTH +: DWIDTH] = lb1_dout;
        win_shift[win_idx(2, KSIZE - 1)*DWIDTH +: DWIDTH] = pix_in;
    end

    // Counters and output register. An accept always replaces the output, so a drain and
    // a new window in the same cycle leave no bubble; windows whose rows or columns would
    // reach into stale data are marked invalid.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        if (acc) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
            win_d       = win_shift;
            win_valid_d = (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);
            win_last_d  = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
        end
    end

    assign win_out   = win_q;
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;

endmodule

// File: tb/tb_window_stream_3x3.sv
// Directed bench for window_stream_3x3 on a 4x4 image whose pixel value is row*16+col.
// A negedge monitor captures every window handed over (win_valid & win_ready) and the
// main sequence compares the captured list against windows derived from pixel coordinates.
module tb_window_stream_3x3;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 4;

   logic          clk;
   logic          rst;
   logic [DW-1:0] pixIn;
   logic          pixSof;
   logic          pixValid;
   logic          pixReady;
   logic [71:0]   winOut;
   logic          winValid;
   logic          winReady;
   logic          winLast;

   int errors = 0;
   int checks = 0;
   int cycleCount = 0;
   int stallCount = 0;

   logic [71:0] gotWin[$];
   logic        gotLast[$];
   int          gotCyc[$];
   logic [71:0] expWinQ[$];
   logic        expLastQ[$];

   window_stream_3x3 #(.DWIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_in    (pixIn),
      .pix_sof   (pixSof),
      .pix_valid (pixValid),
      .pix_ready (pixReady),
      .win_out   (winOut),
      .win_valid (winValid),
      .win_ready (winReady),
      .win_last  (winLast)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to judge whether windows arrive back to back.
   always @(posedge clk) begin
      cycleCount++;
   end

   // Capture handed-over windows and count input stalls, away from the active edge.
   always @(negedge clk) begin
      if (!rst && winValid && winReady) begin
         gotWin.push_back(winOut);
         gotLast.push_back(winLast);
         gotCyc.push_back(cycleCount);
      end
      if (!rst && pixValid && !pixReady) begin
         stallCount++;
      end
   end

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected window centred so that its newest pixel is at (r,c).
   function automatic logic [71:0] expWin(input int r, input int c);
      logic [71:0] w;
      w = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            w[(i*3+j)*8 +: 8] = 8'((r - 2 + i) * 16 + (c - 2 + j));
         end
      end
      return w;
   endfunction

   // Offer one pixel and hold it until accepted (bounded).
   task automatic applyStimulus(input logic [DW-1:0] pix, input logic sof);
      logic accepted;
      int   n;
      pixIn    = pix;
      pixSof   = sof;
      pixValid = 1'b1;
      accepted = 1'b0;
      n = 0;
      while (!accepted && n < 100) begin
         @(negedge clk);
         accepted = pixReady;
         @(posedge clk);
         #1;
         n++;
      end
      if (!accepted) begin
         checkOutput("pix_accept_timeout", 72'd0, 72'd1);
      end
   endtask

   task automatic idleCycles(input int n);
      pixValid = 1'b0;
      pixSof   = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Feed linear pixel indices first..last (idx = r*W+c); sof on sofIdx; gap idle cycles between.
   task automatic feedRange(input int first, input int last, input int gap, input int sofIdx);
      for (int k = first; k <= last; k++) begin
         applyStimulus(8'((k / W) * 16 + (k % W)), k == sofIdx);
         if (gap > 0) idleCycles(gap);
      end
      pixValid = 1'b0;
      pixSof   = 1'b0;
   endtask

   task automatic clearCapture();
      gotWin.delete();
      gotLast.delete();
      gotCyc.delete();
      expWinQ.delete();
      expLastQ.delete();
   endtask

   task automatic addFrameExp();
      for (int r = 2; r < H; r++) begin
         for (int c = 2; c < W; c++) begin
            expWinQ.push_back(expWin(r, c));
            expLastQ.push_back(r == H - 1 && c == W - 1);
         end
      end
   endtask

   task automatic compareCapture(input string tag);
      int n;
      checkOutput({tag, "_count"}, 72'(gotWin.size()), 72'(expWinQ.size()));
      n = (gotWin.size() < expWinQ.size()) ? gotWin.size() : expWinQ.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s_win%0d", tag, i), gotWin[i], expWinQ[i]);
         checkOutput($sformatf("%s_last%0d", tag, i), 72'(gotLast[i]), 72'(expLastQ[i]));
      end
   endtask

   initial begin
      int stallBase;
      int lastCount;
      rst      = 1'b1;
      pixIn    = '0;
      pixSof   = 1'b0;
      pixValid = 1'b0;
      winReady = 1'b1;

      // Reset state
      @(negedge clk);
      checkOutput("rst_win_valid", 72'(winValid), 72'd0);
      checkOutput("rst_win_last", 72'(winLast), 72'd0);
      checkOutput("rst_win_out", winOut, 72'd0);
      checkOutput("rst_pix_ready", 72'(pixReady), 72'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idleCycles(2);

      // Test 1: full frame with idle gaps
      clearCapture();
      addFrameExp();
      feedRange(0, 15, 1, 0);
      idleCycles(4);
      compareCapture("t1");
      if (gotWin.size() == 4) begin
         checkOutput("t1_first_e00", 72'(gotWin[0][7:0]), 72'h00);
         checkOutput("t1_first_e11", 72'(gotWin[0][39:32]), 72'h11);
         checkOutput("t1_first_e22", 72'(gotWin[0][71:64]), 72'h22);
         checkOutput("t1_last_e22", 72'(gotWin[3][71:64]), 72'h33);
         checkOutput("t1_last_flag", 72'(gotLast[3]), 72'd1);
      end

      // Test 2: backpressure on the first window
      clearCapture();
      addFrameExp();
      feedRange(0, 10, 0, 0);
      winReady = 1'b0;
      pixIn    = 8'h23;
      pixSof   = 1'b0;
      pixValid = 1'b1;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         checkOutput($sformatf("t2_stall_valid%0d", s), 72'(winValid), 72'd1);
         checkOutput($sformatf("t2_stall_win%0d", s), winOut, expWin(2, 2));
         checkOutput($sformatf("t2_stall_ready%0d", s), 72'(pixReady), 72'd0);
         @(posedge clk);
         #1;
      end
      winReady = 1'b1;
      feedRange(11, 15, 0, -1);
      idleCycles(4);
      compareCapture("t2");

      // Test 3: full throughput
      clearCapture();
      addFrameExp();
      stallBase = stallCount;
      feedRange(0, 15, 0, 0);
      idleCycles(4);
      checkOutput("t3_no_stall", 72'(stallCount - stallBase), 72'd0);
      compareCapture("t3");
      if (gotCyc.size() == 4) begin
         checkOutput("t3_consec_row2", 72'(gotCyc[1] - gotCyc[0]), 72'd1);
         checkOutput("t3_consec_row3", 72'(gotCyc[3] - gotCyc[2]), 72'd1);
      end

      // Test 4: sof mid-frame at (3,1), then a clean frame
      clearCapture();
      expWinQ.push_back(expWin(2, 2));
      expLastQ.push_back(1'b0);
      expWinQ.push_back(expWin(2, 3));
      expLastQ.push_back(1'b0);
      addFrameExp();
      feedRange(0, 12, 0, 0);
      feedRange(13, 15, 0, 13);
      feedRange(0, 15, 0, 0);
      idleCycles(4);
      compareCapture("t4");

      // Test 5: reset while a window is pending
      clearCapture();
      feedRange(0, 10, 0, 0);
      winReady = 1'b0;
      @(negedge clk);
      checkOutput("t5_pending_valid", 72'(winValid), 72'd1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("t5_rst_valid_async", 72'(winValid), 72'd0);
      @(negedge clk);
      checkOutput("t5_rst_valid", 72'(winValid), 72'd0);
      checkOutput("t5_rst_win_out", winOut, 72'd0);
      checkOutput("t5_rst_last", 72'(winLast), 72'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      winReady = 1'b1;
      clearCapture();
      addFrameExp();
      feedRange(0, 15, 0, 0);
      idleCycles(4);
      compareCapture("t5");

      // Test 6: two frames back to back
      clearCapture();
      addFrameExp();
      addFrameExp();
      feedRange(0, 15, 0, 0);
      feedRange(0, 15, 0, 0);
      idleCycles(4);
      compareCapture("t6");
      lastCount = 0;
      foreach (gotLast[i]) begin
         if (gotLast[i]) lastCount++;
      end
      checkOutput("t6_last_count", 72'(lastCount), 72'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
